// File: rtl/fpga_debug_pkg.sv
// Shared types and helpers for the FPGA bring-up debug display blocks.
package fpga_debug_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {LIVE, HOLD, RECAP} pager_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low segment pattern, bit order g..a
    function automatic seg7_t hex2seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h27;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one raw active-low key; emits a one-cycle press pulse.
module key_debounce
    import fpga_debug_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_n,
    output logic press
);

    localparam int CW = clog2_min1(DEBOUNCE_CYC);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchroniser resets to "pressed" and the key is disarmed until a stable
    // release is seen, so a key held through reset cannot generate an event.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= '0;
            level  <= 1'b1;
            armed  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            press  <= 1'b0;
            if (!armed) begin
                if (!sync_q[1]) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_q[1];
                cnt   <= '0;
                press <= ~sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_pager.sv
// Multi-channel, multi-page registered hex display driver with freeze and key stepping.
module hex_pager
    import fpga_debug_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NDIGITS      = 8,
    parameter int NCHAN        = 4,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NCHAN*DATA_W-1:0]   chan_data,
    input  logic                      key_chan_n,
    input  logic                      key_page_n,
    input  logic                      hold,
    input  logic                      blank_lz,
    output logic [7*NDIGITS-1:0]      seg_n,
    output logic [clog2_min1(NCHAN)-1:0] chan_sel,
    output logic [clog2_min1((DATA_W + 4*NDIGITS - 1) / (4*NDIGITS))-1:0] page_sel,
    output logic                      held
);

    localparam int NPAGES = (DATA_W + 4*NDIGITS - 1) / (4*NDIGITS);
    localparam int CW     = clog2_min1(NCHAN);
    localparam int PW     = clog2_min1(NPAGES);
    localparam int TOT    = 4 * NPAGES * NDIGITS;
    localparam int unsigned ND = NDIGITS;

    logic               chan_press;
    logic               page_press;
    pager_state_t       state;
    logic [DATA_W-1:0]  snapshot;
    logic [DATA_W-1:0]  sel_word;
    logic [TOT-1:0]     pad;
    logic [7*NDIGITS-1:0] seg_next;
    logic [3:0]         nib;
    int unsigned        idx;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_chan (
        .CLK   (CLK),
        .nRST  (nRST),
        .key_n (key_chan_n),
        .press (chan_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_page (
        .CLK   (CLK),
        .nRST  (nRST),
        .key_n (key_page_n),
        .press (page_press)
    );

    assign sel_word = DATA_W'(chan_data >> (32'(chan_sel) * DATA_W));
    assign pad      = TOT'(snapshot);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            chan_sel <= '0;
            page_sel <= '0;
        end else if (chan_press) begin
            chan_sel <= (chan_sel == CW'(NCHAN - 1)) ? '0 : chan_sel + 1'b1;
            page_sel <= '0;
        end else if (page_press) begin
            page_sel <= (page_sel == PW'(NPAGES - 1)) ? '0 : page_sel + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= LIVE;
            snapshot <= '0;
            held     <= 1'b0;
        end else begin
            case (state)
                LIVE: begin
                    snapshot <= sel_word;
                    if (hold) begin
                        state <= HOLD;
                        held  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (chan_press) begin
                        state <= RECAP;
                        held  <= 1'b1;
                    end else if (!hold) begin
                        state <= LIVE;
                        held  <= 1'b0;
                    end
                end
                default: begin
                    snapshot <= sel_word;
                    state    <= hold ? HOLD : LIVE;
                    held     <= hold;
                end
            endcase
        end
    end

    // A digit is blank when its nibble and all higher nibbles of the word are zero
    always_comb begin
        seg_next = '1;
        nib      = '0;
        idx      = 0;
        for (int unsigned d = 0; d < ND; d++) begin
            idx = 32'(page_sel) * ND + d;
            nib = 4'(pad >> (4 * idx));
            if (blank_lz && (idx != 0) && ((pad >> (4 * idx)) == '0))
                seg_next[7*d +: 7] = SEG_BLANK;
            else
                seg_next[7*d +: 7] = hex2seg(nib);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            seg_n <= '1;
        else
            seg_n <= seg_next;
    end

endmodule

// File: tb/tb_hex_pager.sv
// Scoreboard bench for hex_pager: directed key/hold/reset scenarios with hand-computed displays.
module tb_hex_pager;

    localparam int DATA_W = 40;
    localparam int NDIGITS = 8;
    localparam int NCHAN = 4;
    localparam int DEBOUNCE_CYC = 4;

    localparam logic [55:0] E_BLANK = {8{7'h7F}};
    localparam logic [55:0] E_INIT  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h27, 7'h21};
    localparam logic [55:0] E_FIVE  = {{7{7'h7F}}, 7'h12};
    localparam logic [55:0] E_P0    = {{7{7'h40}}, 7'h79};
    localparam logic [55:0] E_P1    = {{6{7'h40}}, 7'h0E, 7'h06};
    localparam logic [55:0] E_P1B   = {{6{7'h7F}}, 7'h0E, 7'h06};
    localparam logic [55:0] E_777   = {{5{7'h7F}}, {3{7'h78}}};

    localparam int K_SEG = 0, K_CHAN = 1, K_PAGE = 2, K_HELD = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [55:0] val;
    } exp_t;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic [DATA_W-1:0] ch [NCHAN];
    logic [NCHAN*DATA_W-1:0] chan_data;
    logic              key_chan_n = 1'b1;
    logic              key_page_n = 1'b1;
    logic              hold = 1'b0;
    logic              blank_lz = 1'b0;
    logic [7*NDIGITS-1:0] seg_n;
    logic [1:0]        chan_sel;
    logic [0:0]        page_sel;
    logic              held;

    exp_t        q[$];
    exp_t        e;
    logic [55:0] act;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign chan_data = {ch[3], ch[2], ch[1], ch[0]};

    always #5 CLK = ~CLK;

    hex_pager #(
        .DATA_W(DATA_W),
        .NDIGITS(NDIGITS),
        .NCHAN(NCHAN),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .chan_data(chan_data),
        .key_chan_n(key_chan_n),
        .key_page_n(key_page_n),
        .hold(hold),
        .blank_lz(blank_lz),
        .seg_n(seg_n),
        .chan_sel(chan_sel),
        .page_sel(page_sel),
        .held(held)
    );

    // Monitor: drains expectations on the falling edge, away from the active edge
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_SEG:   act = seg_n;
                K_CHAN:  act = 56'(chan_sel);
                K_PAGE:  act = 56'(page_sel);
                default: act = 56'(held);
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input string name, input int kind, input logic [55:0] v);
        q.push_back('{name, kind, v});
    endtask

    // which: 0 channel key, 1 page key, 2 both in the same cycle
    task automatic press_key(input int which);
        if (which != 1) key_chan_n = 1'b0;
        if (which != 0) key_page_n = 1'b0;
        step(8);
        key_chan_n = 1'b1;
        key_page_n = 1'b1;
        step(8);
    endtask

    initial begin
        ch[0] = 40'h00_1234_ABCD;
        ch[1] = 40'h5;
        ch[2] = 40'h22;
        ch[3] = 40'h33;

        step(3);
        expect_val("reset_seg", K_SEG, E_BLANK);
        expect_val("reset_chan", K_CHAN, 56'd0);
        expect_val("reset_page", K_PAGE, 56'd0);
        expect_val("reset_held", K_HELD, 56'd0);
        step(1);
        nRST = 1'b1;
        step(2);
        expect_val("init_display", K_SEG, E_INIT);
        step(10);

        // short glitch must be ignored, long press accepted once
        key_chan_n = 1'b0;
        step(3);
        key_chan_n = 1'b1;
        step(8);
        expect_val("glitch_chan", K_CHAN, 56'd0);
        blank_lz = 1'b1;
        key_chan_n = 1'b0;
        step(12);
        key_chan_n = 1'b1;
        step(10);
        expect_val("long_press_chan", K_CHAN, 56'd1);
        expect_val("ch1_blanked", K_SEG, E_FIVE);

        press_key(0);
        press_key(0);
        expect_val("chan_three", K_CHAN, 56'd3);
        ch[0] = 40'hFE_0000_0001;
        blank_lz = 1'b0;
        press_key(0);
        expect_val("chan_wrap", K_CHAN, 56'd0);
        expect_val("page0_display", K_SEG, E_P0);

        press_key(1);
        expect_val("page_one", K_PAGE, 56'd1);
        expect_val("page1_unblanked", K_SEG, E_P1);
        blank_lz = 1'b1;
        step(2);
        expect_val("page1_blanked", K_SEG, E_P1B);
        press_key(1);
        expect_val("page_wrap", K_PAGE, 56'd0);
        expect_val("page0_blanked", K_SEG, E_P0);

        // freeze, recapture on channel press, then resume tracking
        hold = 1'b1;
        step(3);
        ch[0] = 40'h0;
        step(4);
        expect_val("hold_frozen", K_SEG, E_P0);
        expect_val("hold_held", K_HELD, 56'd1);
        press_key(0);
        ch[1] = 40'h777;
        step(4);
        expect_val("recap_chan", K_CHAN, 56'd1);
        expect_val("recap_frozen", K_SEG, E_FIVE);
        expect_val("recap_held", K_HELD, 56'd1);
        hold = 1'b0;
        step(4);
        expect_val("live_again_seg", K_SEG, E_777);
        expect_val("live_again_held", K_HELD, 56'd0);

        press_key(0);
        press_key(0);
        press_key(1);
        expect_val("pre_both_chan", K_CHAN, 56'd3);
        expect_val("pre_both_page", K_PAGE, 56'd1);
        press_key(2);
        expect_val("both_chan", K_CHAN, 56'd0);
        expect_val("both_page", K_PAGE, 56'd0);

        // reset in HOLD with a key mid-debounce
        press_key(0);
        press_key(0);
        hold = 1'b1;
        step(3);
        expect_val("pre_rst_chan", K_CHAN, 56'd2);
        expect_val("pre_rst_held", K_HELD, 56'd1);
        step(1);
        key_chan_n = 1'b0;
        step(3);
        nRST = 1'b0;
        #1;
        expect_val("async_rst_seg", K_SEG, E_BLANK);
        expect_val("async_rst_chan", K_CHAN, 56'd0);
        expect_val("async_rst_held", K_HELD, 56'd0);
        step(2);
        hold = 1'b0;
        nRST = 1'b1;
        step(20);
        expect_val("held_key_no_event", K_CHAN, 56'd0);
        expect_val("post_rst_held", K_HELD, 56'd0);
        key_chan_n = 1'b1;
        step(10);
        press_key(0);
        expect_val("repress_chan", K_CHAN, 56'd1);
        step(2);

        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
